// File: rtl/y86_regfile_pkg.sv
// Shared Y86-64 register-file definitions: register ids, sizes and
// the dump-engine state encoding used by the regfile and its dump unit.
`timescale 1ns/1ps
package y86_pkg;
    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         NUM_REGS = 15;

    typedef logic [3:0] reg_id_t;

    typedef enum logic {
        DUMP_IDLE,
        DUMP_SEND
    } dump_state_e;
endpackage

// File: rtl/y86_regfile_if.sv
// Register dump stream: request/busy plus a valid/ready beat of
// (idx, data, last). master = regfile side, slave = consumer side.
`timescale 1ns/1ps
import y86_pkg::*;

interface y86_regfile_if;
    logic        dump_req;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready;
    reg_id_t     dump_idx;
    logic [63:0] dump_data;
    logic        dump_last;

    modport master (
        input  dump_req, dump_ready,
        output dump_busy, dump_valid, dump_idx, dump_data, dump_last
    );

    modport slave (
        output dump_req, dump_ready,
        input  dump_busy, dump_valid, dump_idx, dump_data, dump_last
    );
endinterface

// File: rtl/y86_regfile_dump.sv
// Dump engine: IDLE/SEND FSM that walks ids 0..14, holding one beat.
// Ports: clk, rst_n, o_rd_idx/i_rd_data (storage read), dump (master).
`timescale 1ns/1ps
import y86_pkg::*;

module y86_regfile_dump (
    input  logic                 clk,
    input  logic                 rst_n,
    output reg_id_t              o_rd_idx,
    input  logic [63:0]          i_rd_data,
    y86_regfile_if.master        dump
);
    localparam reg_id_t LAST_IDX = reg_id_t'(NUM_REGS - 1);

    dump_state_e r_state;
    reg_id_t     r_idx;
    logic [63:0] r_data;

    // Storage is read at the id that will be captured on the next
    // accepted edge: 0 when starting, idx+1 while sending.
    assign o_rd_idx = (r_state == DUMP_IDLE) ? '0 : r_idx + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DUMP_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                DUMP_IDLE: begin
                    if (dump.dump_req) begin
                        r_idx   <= '0;
                        r_data  <= i_rd_data;
                        r_state <= DUMP_SEND;
                    end
                end
                DUMP_SEND: begin
                    if (dump.dump_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= DUMP_IDLE;
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_data <= i_rd_data;
                        end
                    end
                end
            endcase
        end
    end

    assign dump.dump_valid = (r_state == DUMP_SEND);
    assign dump.dump_busy  = (r_state == DUMP_SEND);
    assign dump.dump_idx   = r_idx;
    assign dump.dump_data  = r_data;
    assign dump.dump_last  = (r_state == DUMP_SEND) && (r_idx == LAST_IDX);
endmodule

// File: rtl/y86_regfile.sv
// Y86-64 SEQ register file: 2 combinational reads, 2 writes, dump port.
// Ports: clk, rst_n, srcA/srcB->valA/valB, dstE/valE, dstM/valM, dump.
`timescale 1ns/1ps
import y86_pkg::*;

module y86_regfile #(
    parameter logic [63:0] RSP_INIT = 64'd0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  reg_id_t       srcA,
    input  reg_id_t       srcB,
    output logic [63:0]   valA,
    output logic [63:0]   valB,
    input  reg_id_t       dstE,
    input  logic [63:0]   valE,
    input  reg_id_t       dstM,
    input  logic [63:0]   valM,
    y86_regfile_if.master dump
);
    logic [63:0] r_regs [NUM_REGS];
    reg_id_t     w_dump_idx;
    logic [63:0] w_dump_rd;

    // M is written after E so that dstE==dstM resolves to valM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (4'(i) == REG_RSP) ? RSP_INIT : '0;
            end
        end else begin
            if (dstE != RNONE) r_regs[dstE] <= valE;
            if (dstM != RNONE) r_regs[dstM] <= valM;
        end
    end

    function automatic logic [63:0] read_port(reg_id_t src);
        logic [63:0] v;
        v = (src == RNONE) ? '0 : r_regs[src];
        // M has priority over E, mirroring the write conflict rule.
        if (BYPASS && src != RNONE) begin
            priority case (1'b1)
                (src == dstM): v = valM;
                (src == dstE): v = valE;
                default:       ;
            endcase
        end
        return v;
    endfunction

    always_comb begin
        valA = read_port(srcA);
        valB = read_port(srcB);
    end

    // Dump sees pre-edge stored contents only, never the bypass.
    assign w_dump_rd = (w_dump_idx == RNONE) ? '0 : r_regs[w_dump_idx];

    y86_regfile_dump u_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_rd_idx  (w_dump_idx),
        .i_rd_data (w_dump_rd),
        .dump      (dump)
    );
endmodule

// File: tb/tb_y86_regfile.sv
// Bench for y86_regfile: array reference model, dump-beat scoreboard.
// Ports: none; drives the DUT and an y86_regfile_if instance.
`timescale 1ns/1ps
import y86_pkg::*;

module tb_y86_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    reg_id_t     srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, valE, valM;

    always #5 clk = ~clk;

    y86_regfile_if dif ();

    y86_regfile #(
        .RSP_INIT (64'h100),
        .BYPASS   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .srcA  (srcA),
        .srcB  (srcB),
        .valA  (valA),
        .valB  (valB),
        .dstE  (dstE),
        .valE  (valE),
        .dstM  (dstM),
        .valM  (valM),
        .dump  (dif.master)
    );

    typedef struct {
        int          idx;
        logic [63:0] data;
    } beat_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] m [15];
    beat_t       q [$];
    bit          active;
    int          cur;
    beat_t       mon_b;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(reg_id_t s);
        if (s == 4'hF) return 64'd0;
        if (dstM != 4'hF && s == dstM) return valM;
        if (dstE != 4'hF && s == dstE) return valE;
        return m[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m[i] = (i == 4) ? 64'h100 : 64'd0;
        active = 1'b0;
        cur    = 0;
        q.delete();
    endtask

    task automatic idle_in();
        srcA = 4'hF; srcB = 4'hF;
        dstE = 4'hF; dstM = 4'hF;
        valE = '0;   valM = '0;
        dif.dump_req = 1'b0;
    endtask

    // One clock: check reads, advance the transaction-level dump model
    // (captures happen before this cycle's writes land), apply writes.
    task automatic cyc();
        #1;
        chk("valA", valA, exp_rd(srcA));
        chk("valB", valB, exp_rd(srcB));
        chk("dump_valid", 64'(dif.dump_valid), 64'(active));
        chk("dump_busy", 64'(dif.dump_busy), 64'(active));
        if (!active) begin
            if (dif.dump_req) begin
                q.push_back('{0, m[0]});
                active = 1'b1;
                cur    = 0;
            end
        end else if (dif.dump_ready) begin
            if (cur == 14) begin
                active = 1'b0;
            end else begin
                cur++;
                q.push_back('{cur, m[cur]});
            end
        end
        if (dstE != 4'hF) m[dstE] = valE;
        if (dstM != 4'hF) m[dstM] = valM;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 64'(dif.dump_busy), 64'd0);
        chk("rst_valid", 64'(dif.dump_valid), 64'd0);
        chk("rst_idx", 64'(dif.dump_idx), 64'd0);
        chk("rst_data", dif.dump_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dif.dump_valid && dif.dump_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dump_extra: got beat idx %0d expected none",
                         dif.dump_idx);
            end else begin
                mon_b = q.pop_front();
                chk("dump_idx", 64'(dif.dump_idx), 64'(mon_b.idx));
                chk("dump_data", dif.dump_data, mon_b.data);
                chk("dump_last", 64'(dif.dump_last), 64'(mon_b.idx == 14));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        idle_in();
        dif.dump_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        srcA = 4'h4; srcB = 4'h0;
        #1;
        chk("rst_rsp", valA, 64'h100);
        chk("rst_r0", valB, 64'd0);
        srcA = 4'hF;
        #1;
        chk("rnone", valA, 64'd0);
        chk("rst_idx0", 64'(dif.dump_idx), 64'd0);

        dstE = 4'h0; valE = 64'h6;
        cyc();
        dstE = 4'hF; valE = 64'hDEAD; srcA = 4'h0;
        #1;
        chk("wr_r0", valA, 64'h6);
        for (int i = 0; i < 15; i++) begin
            srcA = reg_id_t'(i);
            srcB = reg_id_t'(14 - i);
            cyc();
        end

        dstE = 4'h4; dstM = 4'h4;
        valE = 64'h10; valM = 64'h20; srcA = 4'h4;
        #1;
        chk("conflict_byp", valA, 64'h20);
        cyc();
        dstE = 4'hF; dstM = 4'hF;
        #1;
        chk("conflict_wr", valA, 64'h20);
        cyc();

        dstE = 4'h2; valE = 64'h55; srcB = 4'h2;
        #1;
        chk("bypass_b", valB, 64'h55);
        cyc();
        dstE = 4'hF;

        for (int i = 0; i < 15; i++) begin
            dstE = reg_id_t'(i);
            valE = 64'(i + 1);
            cyc();
        end
        idle_in();

        dif.dump_req = 1'b1; dif.dump_ready = 1'b1;
        cyc();
        dif.dump_req = 1'b0;
        n = 0;
        while (active && n < 40) begin
            cyc();
            n++;
        end
        if (active) chk("dump1_done", 64'd1, 64'd0);
        chk("busy_after", 64'(dif.dump_busy), 64'd0);
        cyc();

        dif.dump_req = 1'b1; dif.dump_ready = 1'b0;
        cyc();
        n = 0;
        while (n < 200) begin
            if (active && cur == 7) break;
            dif.dump_ready = n[0];
            dif.dump_req   = (n % 5 == 0);
            if (active && cur == 3) begin
                dstE = 4'h3; valE = 64'hAAAA;
            end else begin
                dstE = 4'hF;
            end
            srcA = 4'h3;
            cyc();
            n++;
        end
        if (!(active && cur == 7)) chk("dump2_beat7", 64'd0, 64'd1);
        idle_in();
        do_reset();
        srcA = 4'h4; srcB = 4'h3;
        #1;
        chk("rst2_rsp", valA, 64'h100);
        chk("rst2_r3", valB, 64'd0);
        cyc();

        repeat (400) begin
            srcA = reg_id_t'($urandom_range(0, 15));
            srcB = reg_id_t'($urandom_range(0, 15));
            dstE = reg_id_t'($urandom_range(0, 15));
            dstM = ($urandom_range(0, 2) == 0) ? dstE
                                               : reg_id_t'($urandom_range(0, 15));
            valE = {$urandom, $urandom};
            valM = {$urandom, $urandom};
            dif.dump_req   = ($urandom_range(0, 3) == 0);
            dif.dump_ready = $urandom_range(0, 1) != 0;
            cyc();
        end

        idle_in();
        dif.dump_ready = 1'b1;
        n = 0;
        while (active && n < 40) begin
            cyc();
            n++;
        end
        if (active) chk("drain_done", 64'd1, 64'd0);
        @(negedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
